// File: rtl/lms_log2.sv
// lms_log2: 3-stage pipelined log2 of three unsigned 8.8 LMS channels to signed Q4.8.
// Define LMS_LOG_CORR_EN to add the 16-entry correction LUT on top of the Mitchell estimate.
module lms_log2 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [15:0] i_L,
    input  logic [15:0] i_M,
    input  logic [15:0] i_S,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [11:0] o_logL,
    output logic [11:0] o_logM,
    output logic [11:0] o_logS
);

    logic        adv;
    logic [15:0] x      [3];

    logic        v1, v2, v3;
    logic [3:0]  p1     [3];
    logic [7:0]  m1     [3];
    logic [7:0]  frac2  [3];
    logic [3:0]  int2   [3];
    logic [11:0] res3   [3];

    logic [3:0]  p_d    [3];
    logic [7:0]  m_d    [3];
    logic [11:0] res_d  [3];

`ifdef LMS_LOG_CORR_EN
    logic [4:0]  corr2  [3];
    logic [4:0]  corr_d [3];
    logic [12:0] sum_d  [3];
`endif

    function automatic logic [3:0] lead_one(input logic [15:0] val);
        logic [3:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (val[i]) idx = 4'(i);
        end
        return idx;
    endfunction

`ifdef LMS_LOG_CORR_EN
    // round(256 * (log2(1 + k/16) - k/16))
    function automatic logic [4:0] corr_lut(input logic [3:0] k);
        logic [4:0] c;
        case (k)
            4'd0:  c = 5'd0;
            4'd1:  c = 5'd6;
            4'd2:  c = 5'd12;
            4'd3:  c = 5'd15;
            4'd4:  c = 5'd18;
            4'd5:  c = 5'd20;
            4'd6:  c = 5'd22;
            4'd7:  c = 5'd22;
            4'd8:  c = 5'd22;
            4'd9:  c = 5'd21;
            4'd10: c = 5'd19;
            4'd11: c = 5'd17;
            4'd12: c = 5'd15;
            4'd13: c = 5'd12;
            4'd14: c = 5'd8;
            4'd15: c = 5'd4;
        endcase
        return c;
    endfunction
`endif

    assign x[0] = i_L;
    assign x[1] = i_M;
    assign x[2] = i_S;

    assign adv     = !v3 || i_ready;
    assign o_ready = adv;
    assign o_valid = v3;
    assign o_logL  = res3[0];
    assign o_logM  = res3[1];
    assign o_logS  = res3[2];

    // S1 inputs: leading-one index and the 8 bits just below it (bits [14:7] once left-aligned)
    always_comb begin
        for (int unsigned c = 0; c < 3; c++) begin
            p_d[c] = lead_one(x[c]);
            m_d[c] = 8'((x[c] << (4'd15 - p_d[c])) >> 7);
        end
    end

`ifdef LMS_LOG_CORR_EN
    always_comb begin
        for (int unsigned c = 0; c < 3; c++) begin
            corr_d[c] = corr_lut(m1[c][7:4]);
            // corr is non-negative, so only positive overflow needs clamping
            sum_d[c]  = {int2[c][3], int2[c], frac2[c]} + {8'b0, corr2[c]};
            if (!sum_d[c][12] && sum_d[c][11]) res_d[c] = 12'h7FF;
            else                               res_d[c] = sum_d[c][11:0];
        end
    end
`else
    always_comb begin
        for (int unsigned c = 0; c < 3; c++) begin
            res_d[c] = {int2[c], frac2[c]};
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            for (int unsigned c = 0; c < 3; c++) begin
                p1[c]    <= '0;
                m1[c]    <= '0;
                frac2[c] <= '0;
                int2[c]  <= '0;
                res3[c]  <= '0;
`ifdef LMS_LOG_CORR_EN
                corr2[c] <= '0;
`endif
            end
        end else if (adv) begin
            v1 <= i_valid;
            v2 <= v1;
            v3 <= v2;
            for (int unsigned c = 0; c < 3; c++) begin
                p1[c]    <= p_d[c];
                m1[c]    <= m_d[c];
                frac2[c] <= m1[c];
                int2[c]  <= p1[c] - 4'd8;
                res3[c]  <= res_d[c];
`ifdef LMS_LOG_CORR_EN
                corr2[c] <= corr_d[c];
`endif
            end
        end
    end

endmodule

// File: tb/tb_lms_log2.sv
// tb_lms_log2: directed vectors into a scoreboard queue, checked by an independent output monitor.
module tb_lms_log2;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        ready_out;
    logic [15:0] l_in, m_in, s_in;
    logic        valid_out;
    logic        ready_in;
    logic [11:0] log_l, log_m, log_s;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit lat_en = 1'b1;

    logic [35:0] exp_q [$];
    int          cyc_q [$];
    bit          lat_q [$];

    lms_log2 dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid_in),
        .o_ready (ready_out),
        .i_L     (l_in),
        .i_M     (m_in),
        .i_S     (s_in),
        .o_valid (valid_out),
        .i_ready (ready_in),
        .o_logL  (log_l),
        .o_logM  (log_m),
        .o_logS  (log_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Hand-computed log2 results: {Mitchell, corrected}
    function automatic logic [11:0] exp_of(input logic [15:0] v);
        logic [11:0] b, c;
        case (v)
            16'h0000: begin b = 12'h800; c = 12'h800; end
            16'h0001: begin b = 12'h800; c = 12'h800; end
            16'h0002: begin b = 12'h900; c = 12'h900; end
            16'h0003: begin b = 12'h980; c = 12'h996; end
            16'h0010: begin b = 12'hC00; c = 12'hC00; end
            16'h0040: begin b = 12'hE00; c = 12'hE00; end
            16'h00C0: begin b = 12'hF80; c = 12'hF96; end
            16'h0100: begin b = 12'h000; c = 12'h000; end
            16'h0120: begin b = 12'h020; c = 12'h02C; end
            16'h0140: begin b = 12'h040; c = 12'h052; end
            16'h0180: begin b = 12'h080; c = 12'h096; end
            16'h01E0: begin b = 12'h0E0; c = 12'h0E8; end
            16'h0200: begin b = 12'h100; c = 12'h100; end
            16'h0300: begin b = 12'h180; c = 12'h196; end
            16'h0800: begin b = 12'h300; c = 12'h300; end
            16'h1000: begin b = 12'h400; c = 12'h400; end
            16'h4000: begin b = 12'h600; c = 12'h600; end
            16'h7FFF: begin b = 12'h6FF; c = 12'h703; end
            16'h8000: begin b = 12'h700; c = 12'h700; end
            16'hFFFF: begin b = 12'h7FF; c = 12'h7FF; end
            default:  begin b = 'x;      c = 'x;      end
        endcase
`ifdef LMS_LOG_CORR_EN
        return c;
`else
        return b;
`endif
    endfunction

    task automatic send(input logic [15:0] l, input logic [15:0] m, input logic [15:0] s);
        bit ok;
        bit done;
        int k;
        int t;
        done = 1'b0;
        t = 0;
        valid_in = 1'b1;
        l_in = l;
        m_in = m;
        s_in = s;
        while (!done) begin
            @(negedge clk);
            ok = ready_out;
            k = cyc;
            @(posedge clk);
            if (ok) begin
                exp_q.push_back({exp_of(l), exp_of(m), exp_of(s)});
                cyc_q.push_back(k + 3);
                lat_q.push_back(lat_en);
                done = 1'b1;
            end else if (++t > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=blocked required=accepted");
                done = 1'b1;
            end
        end
        #1;
    endtask

    task automatic stop_in();
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            @(posedge clk);
            t++;
        end
        check("drain", 36'(exp_q.size()), 36'h0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic quiet(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(name, 36'(valid_out), 36'h0);
        end
    endtask

    // Output monitor: pops the scoreboard on every transfer out, checks hold under backpressure
    logic [35:0] held;
    bit          stalled = 1'b0;
    always @(negedge clk) begin
        logic [35:0] e;
        int          c;
        bit          l;
        if (!rst) begin
            if (valid_out && !ready_in) begin
                check("stall_ready", 36'(ready_out), 36'h0);
                if (stalled) check("stall_hold", {log_l, log_m, log_s}, held);
                held = {log_l, log_m, log_s};
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 36'(valid_out), 36'h0);
                end else begin
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    l = lat_q.pop_front();
                    check("data", {log_l, log_m, log_s}, e);
                    if (l) check("latency", 36'(cyc), 36'(c));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        valid_in = 1'b1;
        ready_in = 1'b1;
        l_in = 16'h0100;
        m_in = 16'h0200;
        s_in = 16'h0300;

        // Reset held 2 cycles with i_valid high
        @(posedge clk);
        @(negedge clk);
        check("rst_valid", 36'(valid_out), 36'h0);
        check("rst_data", {log_l, log_m, log_s}, 36'h0);
        check("rst_ready", 36'(ready_out), 36'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid_in = 1'b0;
        quiet("rst_quiet", 4);
        @(posedge clk);
        #1;

        // Exact powers, correction points, zero and saturation
        lat_en = 1'b1;
        send(16'h0100, 16'h0200, 16'h0001);
        stop_in();
        drain();
        send(16'h0180, 16'h0000, 16'hFFFF);
        send(16'hFFFF, 16'hFFFF, 16'hFFFF);
        send(16'h0120, 16'h0140, 16'h01E0);
        send(16'h7FFF, 16'h0003, 16'h00C0);
        stop_in();
        drain();

        // Back-to-back stream with a 4-cycle downstream stall
        lat_en = 1'b0;
        fork
            begin
                send(16'h0003, 16'h0010, 16'h0040);
                send(16'h00C0, 16'h0300, 16'h0800);
                send(16'h1000, 16'h4000, 16'h7FFF);
                send(16'h8000, 16'h0002, 16'h0100);
                send(16'h0120, 16'h0180, 16'h0200);
                send(16'h0140, 16'h01E0, 16'hFFFF);
                send(16'h0000, 16'h0001, 16'h0003);
                send(16'h0800, 16'h1000, 16'h4000);
                stop_in();
            end
            begin
                repeat (4) @(posedge clk);
                #1 ready_in = 1'b0;
                repeat (4) @(posedge clk);
                #1 ready_in = 1'b1;
            end
        join
        drain();

        // Mid-stream reset discards everything in flight
        lat_en = 1'b1;
        send(16'h0100, 16'h0200, 16'h0300);
        send(16'h0800, 16'h1000, 16'h4000);
        send(16'h0040, 16'h00C0, 16'h0010);
        rst = 1'b1;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        cyc_q.delete();
        lat_q.delete();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", 36'(valid_out), 36'h0);
        check("midrst_data", {log_l, log_m, log_s}, 36'h0);
        quiet("midrst_quiet", 4);
        @(posedge clk);
        #1;
        send(16'h0180, 16'h8000, 16'h0002);
        stop_in();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
